// File: rtl/vram_access_arbiter.sv
// rtl/vram_access_arbiter.sv - GPU-priority VRAM arbiter with queued CPU writes (stats under VRAM_ARB_STATS_EN)
module vram_access_arbiter #(
    parameter int VRAM_ADDR_WIDTH = 13,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                       clk_12_5875,
    input  logic                       rst,
    input  logic                       vblank,
    input  logic                       cpu_wr_valid,
    output logic                       cpu_wr_ready,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_wr_addr,
    input  logic [7:0]                 cpu_wr_data,
    input  logic                       gpu_rd_req,
    input  logic [VRAM_ADDR_WIDTH-1:0] gpu_rd_addr,
    output logic [7:0]                 gpu_rd_data,
    output logic                       gpu_rd_valid,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]                 vram_wdata,
    output logic                       vram_we,
    input  logic [7:0]                 vram_rdata,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0]                stall_cycles,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_high_water,
`endif
    output logic                       wr_pending
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {ST_ACTIVE, ST_VBLANK} state_t;

    state_t                             state;
    logic [VRAM_ADDR_WIDTH+7:0]         fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]         wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]         rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]           count;
    logic [VRAM_ADDR_WIDTH+7:0]         head;
    logic                               empty;
    logic                               push;
    logic                               pop;
    logic                               write_slot;

    assign empty        = (count == '0);
    assign head         = fifo_mem[rd_ptr];
    assign cpu_wr_ready = !rst && (count != DEPTH_CNT);
    assign wr_pending   = !empty;
    assign push         = cpu_wr_valid && cpu_wr_ready;

    // A read request always owns the port; vblank simply guarantees every non-read cycle drains.
    assign write_slot   = !gpu_rd_req || (state == ST_VBLANK && !gpu_rd_req);
    assign pop          = !rst && !empty && write_slot;

    assign vram_we      = pop;
    assign vram_addr    = pop ? head[VRAM_ADDR_WIDTH+7:8] : gpu_rd_addr;
    assign vram_wdata   = head[7:0];
    assign gpu_rd_data  = vram_rdata;

    always_ff @(posedge clk_12_5875) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cpu_wr_addr, cpu_wr_data};
        end
    end

    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state        <= ST_ACTIVE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            gpu_rd_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACTIVE: if (vblank)  state <= ST_VBLANK;
                ST_VBLANK: if (!vblank) state <= ST_ACTIVE;
                default:                state <= ST_ACTIVE;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            gpu_rd_valid <= gpu_rd_req;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            stall_cycles    <= '0;
            fifo_high_water <= '0;
        end else begin
            if (cpu_wr_valid && !cpu_wr_ready && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (count > fifo_high_water) begin
                fifo_high_water <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb/tb_vram_access_arbiter.sv - scoreboard bench for vram_access_arbiter
module tb_vram_access_arbiter;

    logic        clk_12_5875 = 1'b0;
    logic        rst = 1'b1;
    logic        vblank = 1'b0;
    logic        cpu_wr_valid = 1'b0;
    logic        cpu_wr_ready;
    logic [12:0] cpu_wr_addr = '0;
    logic [7:0]  cpu_wr_data = '0;
    logic        gpu_rd_req = 1'b0;
    logic [12:0] gpu_rd_addr = '0;
    logic [7:0]  gpu_rd_data;
    logic        gpu_rd_valid;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic [7:0]  vram_rdata;
    logic        wr_pending;
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_cycles;
    logic [3:0]  fifo_high_water;
`endif

    vram_access_arbiter #(.VRAM_ADDR_WIDTH(13), .FIFO_DEPTH_LOG2(3)) dut (
        .clk_12_5875(clk_12_5875),
        .rst(rst),
        .vblank(vblank),
        .cpu_wr_valid(cpu_wr_valid),
        .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data),
        .gpu_rd_req(gpu_rd_req),
        .gpu_rd_addr(gpu_rd_addr),
        .gpu_rd_data(gpu_rd_data),
        .gpu_rd_valid(gpu_rd_valid),
        .vram_addr(vram_addr),
        .vram_wdata(vram_wdata),
        .vram_we(vram_we),
        .vram_rdata(vram_rdata),
`ifdef VRAM_ARB_STATS_EN
        .stall_cycles(stall_cycles),
        .fifo_high_water(fifo_high_water),
`endif
        .wr_pending(wr_pending)
    );

    always #40 clk_12_5875 = ~clk_12_5875;

    logic [7:0] mem [0:8191];
    always @(posedge clk_12_5875) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [20:0] sb [$];
    int          m_count = 0;
    bit          m_rd_valid = 1'b0;
    bit          m_rd_chk = 1'b0;
    int          m_stall = 0;
    int          m_hw = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit          exp_ready;
        bit          exp_we;
        int          old_count;
        logic [20:0] e;
        @(negedge clk_12_5875);
        exp_ready = !rst && (m_count < 8);
        exp_we    = !rst && !gpu_rd_req && (m_count > 0);
        check("cpu_wr_ready", 32'(cpu_wr_ready), 32'(exp_ready));
        check("vram_we", 32'(vram_we), 32'(exp_we));
        check("wr_pending", 32'(wr_pending), 32'(m_count != 0));
        check("gpu_rd_valid", 32'(gpu_rd_valid), 32'(m_rd_valid));
        if (m_rd_valid && m_rd_chk) check("gpu_rd_data", 32'(gpu_rd_data), 32'h3C);
        if (exp_we) begin
            e = sb.pop_front();
            check("wr_addr", 32'(vram_addr), 32'(e[20:8]));
            check("wr_data", 32'(vram_wdata), 32'(e[7:0]));
        end else if (!rst) begin
            check("rd_addr", 32'(vram_addr), 32'(gpu_rd_addr));
        end
`ifdef VRAM_ARB_STATS_EN
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("fifo_high_water", 32'(fifo_high_water), 32'(m_hw));
`endif
        old_count = m_count;
        if (rst) begin
            sb.delete();
            m_stall = 0;
            m_hw = 0;
        end else begin
            if (cpu_wr_valid && exp_ready) sb.push_back({cpu_wr_addr, cpu_wr_data});
            if (cpu_wr_valid && !exp_ready && m_stall != 16'hFFFF) m_stall++;
            if (old_count > m_hw) m_hw = old_count;
        end
        m_count    = sb.size();
        m_rd_valid = gpu_rd_req && !rst;
        m_rd_chk   = gpu_rd_req && !rst && (gpu_rd_addr == 13'h040);
        @(posedge clk_12_5875);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h040] = 8'h3C;
        gpu_rd_addr = 13'h800;
        @(posedge clk_12_5875);
        #1;
        step();
        rst = 1'b0;
        step();

        // single write drains next cycle
        cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h0123; cpu_wr_data = 8'hA5;
        step();
        cpu_wr_valid = 1'b0;
        repeat (2) step();

        // fill behind continuous reads, then pop+push in one cycle while full
        gpu_rd_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h100 + 13'(i); cpu_wr_data = 8'h10 + 8'(i);
            gpu_rd_addr = 13'h800 + 13'(i);
            step();
        end
        gpu_rd_req = 1'b0; cpu_wr_addr = 13'h1FF; cpu_wr_data = 8'hEE;
        step();
        cpu_wr_valid = 1'b0;
        repeat (9) step();

        // vblank drain of 5 entries queued behind reads
        vblank = 1'b1; gpu_rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_valid = 1'b1; cpu_wr_addr = 13'h200 + 13'(i); cpu_wr_data = 8'h50 + 8'(i);
            step();
        end
        cpu_wr_valid = 1'b0; gpu_rd_req = 1'b0;
        repeat (7) step();
        vblank = 1'b0;
        step();

        // read latency, then read dropped by reset
        gpu_rd_req = 1'b1; gpu_rd_addr = 13'h040;
        step();
        gpu_rd_req = 1'b0; gpu_rd_addr = 13'h800;
        step();
        gpu_rd_req = 1'b1; gpu_rd_addr = 13'h040; rst = 1'b1;
        step();
        gpu_rd_req = 1'b0; rst = 1'b0;
        repeat (2) step();

        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            vblank       = ($urandom_range(0, 3) == 0);
            gpu_rd_req   = ($urandom_range(0, 1) == 1);
            gpu_rd_addr  = 13'h800 | 13'($urandom_range(0, 2047));
            cpu_wr_valid = ($urandom_range(0, 2) != 0);
            cpu_wr_addr  = 13'h1000 | 13'($urandom_range(0, 4095));
            cpu_wr_data  = 8'($urandom);
            step();
        end
        rst = 1'b0; gpu_rd_req = 1'b0; cpu_wr_valid = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_access_arbiter.md
Name: vram_access_arbiter

Overview:
- Shares the single-port synchronous VRAM between two requesters: the GPU pixel pipeline (reads) and the CPU bus (writes).
- GPU fetches always win, so scan-out timing is never disturbed.
- CPU writes are queued in a small FIFO and drained into VRAM in idle GPU cycles and during vblank.
- Sits between the CPU bus interface and gpu_m/VRAM, in the GPU clock domain.

Parameters:
- VRAM_ADDR_WIDTH, 13, VRAM address width; matches `VRAM_ADDR_WIDTH.
- FIFO_DEPTH_LOG2, 3, write-FIFO depth is 2**FIFO_DEPTH_LOG2 entries (8 by default).

Ports:
- clk_12_5875  in  1  GPU pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vblank  in  1  high while GPU is in vertical blanking.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  FIFO can accept a write this cycle.
- cpu_wr_addr  in  VRAM_ADDR_WIDTH  CPU write address.
- cpu_wr_data  in  8  CPU write data.
- gpu_rd_req  in  1  GPU read request this cycle.
- gpu_rd_addr  in  VRAM_ADDR_WIDTH  GPU read address.
- gpu_rd_data  out  8  read data (passthrough of vram_rdata).
- gpu_rd_valid  out  1  gpu_rd_data valid; gpu_rd_req delayed by 1 cycle.
- vram_addr  out  VRAM_ADDR_WIDTH  VRAM address (combinational mux).
- vram_wdata  out  8  VRAM write data.
- vram_we  out  1  VRAM write enable.
- vram_rdata  in  8  VRAM sync read data; valid 1 cycle after address.
- wr_pending  out  1  FIFO non-empty; CPU status bit.

Behaviour:
- Reset:
  - FIFO pointers and count = 0.
  - State = ACTIVE.
  - gpu_rd_valid = 0, vram_we = 0, wr_pending = 0, cpu_wr_ready = 1 in the cycle after rst deasserts.
  - While rst is high: cpu_wr_ready = 0, vram_we = 0.
- Reset mid-operation: queued writes are discarded, not flushed; an in-flight gpu_rd_valid is dropped.
- FIFO:
  - Entry = {addr, data}.
  - Push when cpu_wr_valid && cpu_wr_ready.
  - cpu_wr_ready = !full. It is computed from the registered count only; there is no pop-while-full bypass, so a full FIFO rejects a push even in a pop cycle.
  - No empty bypass: a write pushed in cycle N reaches VRAM no earlier than N+1.
  - Pointers wrap modulo depth. Count width is FIFO_DEPTH_LOG2+1.
- State machine, two states (registered):
  - ACTIVE -> VBLANK when vblank = 1.
  - VBLANK -> ACTIVE when vblank = 0.
- Grant rules, per cycle:
  - ACTIVE: if gpu_rd_req, grant GPU: vram_addr = gpu_rd_addr, vram_we = 0, no pop. Otherwise, if FIFO non-empty, grant a write: vram_addr/wdata = FIFO head, vram_we = 1, pop.
  - VBLANK: if FIFO non-empty, grant a write every cycle. gpu_rd_req is still honoured with priority if asserted.
  - No grant: vram_we = 0, vram_addr = gpu_rd_addr.
- Read latency: gpu_rd_valid(N+1) = gpu_rd_req(N) && !rst. gpu_rd_data = vram_rdata.
- Ordering and coherence:
  - Writes are retired in FIFO order.
  - No read/write coherence: a GPU read of an address with a queued write returns old data. Software must use wr_pending.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Starvation: continuous gpu_rd_req with a full FIFO holds cpu_wr_ready low indefinitely. This is legal; the CPU bus stalls.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined:
  - Adds output stall_cycles [15:0].
  - Increments every cycle with cpu_wr_valid && !cpu_wr_ready.
  - Saturates at 16'hFFFF; cleared by rst.
  - Adds output fifo_high_water [FIFO_DEPTH_LOG2:0], the maximum count observed since reset.
- Undefined: neither port exists and no counter logic is synthesised. Arbitration is identical.

Test Plan:
- Reset, no traffic -> after rst = 0, cpu_wr_ready = 1, wr_pending = 0, vram_we = 0, gpu_rd_valid = 0.
- ACTIVE, gpu_rd_req = 0, one CPU write addr 0x0123 data 0xA5 in cycle N -> cycle N+1: vram_we = 1, vram_addr = 0x0123, vram_wdata = 0xA5; cycle N+2: wr_pending = 0.
- gpu_rd_req held high, 9 CPU writes -> first 8 accepted, cpu_wr_ready = 0 on the 9th, vram_we stays 0. Then drop gpu_rd_req -> 8 consecutive writes in push order; cpu_wr_ready returns to 1 one cycle after the first pop.
- vblank = 1, FIFO holding 5 entries, gpu_rd_req = 0 -> 5 back-to-back write cycles, then wr_pending = 0.
- GPU read of address 0x0040 with RAM preloaded to 0x3C -> gpu_rd_valid = 1 with gpu_rd_data = 0x3C exactly 1 cycle later. Also assert rst in the request cycle -> gpu_rd_valid stays 0.
- Full FIFO with a pop and push in the same cycle -> push rejected, count = 7. With VRAM_ARB_STATS_EN defined: stall_cycles increments by 1 per rejected cycle and fifo_high_water = 8.
